key_shift_loader: RTL and testbench
===================================

// Module: key_shift_loader
// PURPOSE
//  Serial key-delivery controller that feeds the key inputs of a MUX-locked netlist.
//  A serial bitstream is shifted into a shadow register and checked with an even-parity bit.
//  A good stream is committed atomically to the key-input bus.
//  Sits between the secure key store / scan port and the locked combinational core.
//  Until a verified commit, the core sees SAFE_KEY.
// PARAMETERS
//  KEY_W      10      number of key bits (2 select bits per inserted MUX)
//  SAFE_KEY   0       value driven on key while no verified key is held
//  RELOAD_EN  0       1: load_start is accepted in LOCKED; 0: LOCKED is terminal until reset
// PORTS
//  CK          in   1      clock, rising edge
//  RST         in   1      reset, asynchronous, active-high
//  load_start  in   1      begin (or restart) a key load
//  sdi         in   1      serial key/parity data, LSB first
//  sdi_valid   in   1      sdi qualifier; one bit consumed per cycle when high in SHIFT/PAR
//  key         out  KEY_W  key bus to locked core (D_0..D_{KEY_W-1})
//  key_valid   out  1      key holds a parity-verified value
//  busy        out  1      state is SHIFT or PAR
//  err         out  1      sticky parity failure
//  bit_cnt     out  ceil(log2(KEY_W+1))  bits accepted in current load
// BEHAVIOUR
//  Reset (async, any state):
//   - State IDLE; key=SAFE_KEY; key_valid=0; err=0; busy=0.
//   - bit_cnt=0; shadow=0.
//  States IDLE, SHIFT, PAR, LOCKED, ERROR. All outputs are registered.
//  IDLE:
//   - load_start -> SHIFT; shadow=0, bit_cnt=0. sdi_valid is ignored.
//  SHIFT:
//   - Each sdi_valid cycle: shadow[bit_cnt]<=sdi; bit_cnt++.
//   - When bit_cnt reaches KEY_W -> PAR.
//   - Gaps in sdi_valid stall without penalty; there is no timeout.
//  PAR:
//   - The next sdi_valid bit is the parity bit p.
//   - If ^shadow ^ p == 0: on the next edge key<=shadow, key_valid=1 -> LOCKED.
//     Key latency is 1 cycle after the parity bit is accepted.
//   - Otherwise -> ERROR; key=SAFE_KEY, key_valid=0, err=1 (fail-secure).
//  LOCKED:
//   - key is held and sdi_valid is ignored.
//   - If RELOAD_EN=1, load_start -> SHIFT. During a reload the old key and key_valid=1 are
//     held unchanged until a new commit.
//   - A failed reload forces SAFE_KEY and key_valid=0.
//   - If RELOAD_EN=0, load_start is ignored.
//  ERROR:
//   - err holds 1 and key=SAFE_KEY.
//   - load_start -> SHIFT and clears err the same edge.
//  load_start in SHIFT/PAR restarts the load: bit_cnt=0, shadow=0, and the bit sampled that
//   cycle is discarded.
//  load_start together with sdi_valid in IDLE/ERROR/LOCKED: start wins and the bit is discarded.
//  busy=1 exactly in SHIFT/PAR.
//  bit_cnt stays at KEY_W in PAR and returns to 0 on leaving PAR.
//  key never changes except on a verified commit, reset, or a parity failure.
//  No partial key is ever visible on key.
// TESTING (KEY_W=10, SAFE_KEY=0)
//  1. Reset, load_start, bits of 10'h2CE LSB-first, parity 0 -> key=10'h2CE and key_valid=1
//     one cycle after the parity bit; busy=0.
//  2. Same bits, parity 1 -> err=1, key=0, key_valid=0; new load_start then good stream
//     -> err=0, key=10'h2CE.
//  3. Stream 10'h155 with random sdi_valid gaps (up to 5 idle cycles), parity 1
//     -> key=10'h155; bit_cnt tracks accepted bits only.
//  4. load_start after 6 bits, then full 10'h3FF + parity 0 -> key=10'h3FF (no stale bits).
//  5. RELOAD_EN=0: LOCKED with 10'h2CE, load_start + 11 bits -> key unchanged.
//     RELOAD_EN=1: key stays 10'h2CE until the new commit; a bad-parity reload gives key=0.
//  6. Assert RST after 7 bits and after commit -> key=0, key_valid=0, state IDLE immediately,
//     without a clock edge.

Source files
------------

// File: rtl/key_shift_loader.sv
// Serial key loader for a MUX-locked core: shifts a key in LSB-first, checks even parity,
// then commits it atomically to the key bus. SAFE_KEY is driven until a verified commit.
module key_shift_loader #(
  parameter int               KEY_W     = 10,
  parameter logic [KEY_W-1:0] SAFE_KEY  = '0,
  parameter bit               RELOAD_EN = 1'b0
) (
  input  logic                         CK,
  input  logic                         RST,
  input  logic                         load_start,
  input  logic                         sdi,
  input  logic                         sdi_valid,
  output logic [KEY_W-1:0]             key,
  output logic                         key_valid,
  output logic                         busy,
  output logic                         err,
  output logic [$clog2(KEY_W+1)-1:0]   bit_cnt
);

  localparam int CW = $clog2(KEY_W + 1);
  localparam logic [CW-1:0] LAST_IDX = CW'(KEY_W - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SHIFT,
    S_PAR,
    S_LOCKED,
    S_ERROR
  } state_t;

  state_t           state_q;
  logic [KEY_W-1:0] shadow_q;
  logic [KEY_W-1:0] key_q;
  logic             key_valid_q;
  logic             busy_q;
  logic             err_q;
  logic [CW-1:0]    cnt_q;

  // Even parity over the shadow key plus the trailing parity bit.
  function automatic logic parity_ok(input logic [KEY_W-1:0] d, input logic p);
    return ~(^d ^ p);
  endfunction

  function automatic logic [KEY_W-1:0] shift_in(input logic [KEY_W-1:0] d,
                                                input logic [CW-1:0]    idx,
                                                input logic             b);
    logic [KEY_W-1:0] r;
    r = d;
    for (int i = 0; i < KEY_W; i++) begin
      if (CW'(i) == idx) r[i] = b;
    end
    return r;
  endfunction

  always_ff @(posedge CK or posedge RST) begin
    if (RST) begin
      state_q     <= S_IDLE;
      shadow_q    <= '0;
      key_q       <= SAFE_KEY;
      key_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
      cnt_q       <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (load_start) begin
            state_q  <= S_SHIFT;
            busy_q   <= 1'b1;
            shadow_q <= '0;
            cnt_q    <= '0;
          end
        end

        S_SHIFT: begin
          // A restart discards whatever bit is on sdi this cycle.
          if (load_start) begin
            shadow_q <= '0;
            cnt_q    <= '0;
          end else if (sdi_valid) begin
            shadow_q <= shift_in(shadow_q, cnt_q, sdi);
            cnt_q    <= cnt_q + CW'(1);
            if (cnt_q == LAST_IDX) state_q <= S_PAR;
          end
        end

        S_PAR: begin
          if (load_start) begin
            state_q  <= S_SHIFT;
            shadow_q <= '0;
            cnt_q    <= '0;
          end else if (sdi_valid) begin
            busy_q <= 1'b0;
            cnt_q  <= '0;
            if (parity_ok(shadow_q, sdi)) begin
              state_q     <= S_LOCKED;
              key_q       <= shadow_q;
              key_valid_q <= 1'b1;
            end else begin
              state_q     <= S_ERROR;
              key_q       <= SAFE_KEY;
              key_valid_q <= 1'b0;
              err_q       <= 1'b1;
            end
          end
        end

        S_LOCKED: begin
          // The committed key stays on the bus during a reload until the next verdict.
          if (RELOAD_EN && load_start) begin
            state_q  <= S_SHIFT;
            busy_q   <= 1'b1;
            shadow_q <= '0;
            cnt_q    <= '0;
          end
        end

        S_ERROR: begin
          if (load_start) begin
            state_q  <= S_SHIFT;
            busy_q   <= 1'b1;
            err_q    <= 1'b0;
            shadow_q <= '0;
            cnt_q    <= '0;
          end
        end

        default: begin
          state_q     <= S_IDLE;
          key_q       <= SAFE_KEY;
          key_valid_q <= 1'b0;
          busy_q      <= 1'b0;
          cnt_q       <= '0;
        end
      endcase
    end
  end

  assign key       = key_q;
  assign key_valid = key_valid_q;
  assign busy      = busy_q;
  assign err       = err_q;
  assign bit_cnt   = cnt_q;

endmodule

// File: tb/tb_key_shift_loader.sv
// Bench for key_shift_loader: two instances (reload disabled / enabled) driven in parallel,
// with expected keys and counts derived from the load rules and computed parity.
module tb_key_shift_loader;
  localparam int KW = 10;
  localparam int CW = $clog2(KW + 1);

  logic CK = 1'b0;
  logic RST = 1'b0;
  logic load_start = 1'b0;
  logic sdi = 1'b0;
  logic sdi_valid = 1'b0;

  logic [KW-1:0] key0, key1;
  logic          kv0, kv1, busy0, busy1, err0, err1;
  logic [CW-1:0] cnt0, cnt1;

  int checks = 0;
  int errors = 0;

  always #5 CK = ~CK;

  key_shift_loader #(.KEY_W(KW), .SAFE_KEY({KW{1'b0}}), .RELOAD_EN(1'b0)) u0 (
    .CK(CK), .RST(RST), .load_start(load_start), .sdi(sdi), .sdi_valid(sdi_valid),
    .key(key0), .key_valid(kv0), .busy(busy0), .err(err0), .bit_cnt(cnt0)
  );

  key_shift_loader #(.KEY_W(KW), .SAFE_KEY({KW{1'b0}}), .RELOAD_EN(1'b1)) u1 (
    .CK(CK), .RST(RST), .load_start(load_start), .sdi(sdi), .sdi_valid(sdi_valid),
    .key(key1), .key_valid(kv1), .busy(busy1), .err(err1), .bit_cnt(cnt1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Compare all outputs of one instance against expected values.
  task automatic chk_dut(input string tag, input int u, input logic [KW-1:0] ek,
                         input logic ekv, input logic eb, input logic ee, input int ecnt);
    if (u == 0) begin
      chk($sformatf("%s u0 key", tag), 32'(key0), 32'(ek));
      chk($sformatf("%s u0 key_valid", tag), 32'(kv0), 32'(ekv));
      chk($sformatf("%s u0 busy", tag), 32'(busy0), 32'(eb));
      chk($sformatf("%s u0 err", tag), 32'(err0), 32'(ee));
      chk($sformatf("%s u0 bit_cnt", tag), 32'(cnt0), 32'(ecnt));
    end else begin
      chk($sformatf("%s u1 key", tag), 32'(key1), 32'(ek));
      chk($sformatf("%s u1 key_valid", tag), 32'(kv1), 32'(ekv));
      chk($sformatf("%s u1 busy", tag), 32'(busy1), 32'(eb));
      chk($sformatf("%s u1 err", tag), 32'(err1), 32'(ee));
      chk($sformatf("%s u1 bit_cnt", tag), 32'(cnt1), 32'(ecnt));
    end
  endtask

  task automatic step(input logic ls, input logic v, input logic d);
    @(negedge CK);
    load_start = ls;
    sdi_valid  = v;
    sdi        = d;
    @(posedge CK);
    #1;
  endtask

  // Reset asserted between edges; outputs must clear with no clock edge.
  task automatic do_reset(input string tag);
    @(posedge CK);
    #2;
    load_start = 1'b0;
    sdi_valid  = 1'b0;
    RST = 1'b1;
    #1;
    chk_dut(tag, 0, '0, 1'b0, 1'b0, 1'b0, 0);
    chk_dut(tag, 1, '0, 1'b0, 1'b0, 1'b0, 0);
    @(negedge CK);
    RST = 1'b0;
  endtask

  // Shift n bits of val LSB-first with random idle gaps; bit_cnt follows accepted bits.
  task automatic send_bits(input string tag, input logic [KW-1:0] val, input int n,
                           input int maxgap, input bit c0, input bit c1);
    for (int i = 0; i < n; i++) begin
      int gap;
      gap = (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0;
      for (int g = 0; g < gap; g++) step(1'b0, 1'b0, 1'($urandom_range(0, 1)));
      if (gap > 0) begin
        if (c0) chk($sformatf("%s gap cnt u0 bit%0d", tag, i), 32'(cnt0), 32'(i));
        if (c1) chk($sformatf("%s gap cnt u1 bit%0d", tag, i), 32'(cnt1), 32'(i));
      end
      step(1'b0, 1'b1, val[i]);
      if (c0) chk($sformatf("%s cnt u0 bit%0d", tag, i), 32'(cnt0), 32'(i + 1));
      if (c1) chk($sformatf("%s cnt u1 bit%0d", tag, i), 32'(cnt1), 32'(i + 1));
    end
  endtask

  initial begin
    logic [KW-1:0] v;
    logic [KW-1:0] rk;

    // ---- reset state and IDLE ignores sdi_valid ----
    do_reset("reset");
    step(1'b0, 1'b1, 1'b1);
    chk_dut("idle_ignore", 0, '0, 1'b0, 1'b0, 1'b0, 0);

    // ---- 1: good stream 2CE, parity 0 ----
    v = 10'h2CE;
    step(1'b1, 1'b0, 1'b0);
    chk_dut("t1 start", 0, '0, 1'b0, 1'b1, 1'b0, 0);
    send_bits("t1", v, KW, 0, 1'b1, 1'b1);
    chk_dut("t1 par_wait", 0, '0, 1'b0, 1'b1, 1'b0, KW);
    step(1'b0, 1'b1, ^v);
    chk_dut("t1 commit", 0, v, 1'b1, 1'b0, 1'b0, 0);
    chk_dut("t1 commit", 1, v, 1'b1, 1'b0, 1'b0, 0);

    // ---- 2: bad parity, then recovery ----
    do_reset("t2 reset");
    step(1'b1, 1'b0, 1'b0);
    send_bits("t2", v, KW, 0, 1'b1, 1'b0);
    step(1'b0, 1'b1, ~(^v));
    chk_dut("t2 bad", 0, '0, 1'b0, 1'b0, 1'b1, 0);
    step(1'b1, 1'b1, 1'b1);
    chk_dut("t2 restart", 0, '0, 1'b0, 1'b1, 1'b0, 0);
    send_bits("t2b", v, KW, 0, 1'b1, 1'b0);
    step(1'b0, 1'b1, ^v);
    chk_dut("t2 recover", 0, v, 1'b1, 1'b0, 1'b0, 0);

    // ---- 3: 155 with gaps, then random keys with gaps ----
    do_reset("t3 reset");
    v = 10'h155;
    step(1'b1, 1'b0, 1'b0);
    send_bits("t3", v, KW, 5, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b0);
    chk("t3 par stall cnt", 32'(cnt0), 32'(KW));
    step(1'b0, 1'b1, 1'b1);
    chk_dut("t3 commit", 0, v, 1'b1, 1'b0, 1'b0, 0);
    for (int r = 0; r < 3; r++) begin
      rk = KW'($urandom_range(0, (1 << KW) - 1));
      do_reset($sformatf("t3r%0d reset", r));
      step(1'b1, 1'b0, 1'b0);
      send_bits($sformatf("t3r%0d", r), rk, KW, 3, 1'b1, 1'b1);
      step(1'b0, 1'b1, ^rk);
      chk_dut($sformatf("t3r%0d commit", r), 0, rk, 1'b1, 1'b0, 1'b0, 0);
      chk_dut($sformatf("t3r%0d commit", r), 1, rk, 1'b1, 1'b0, 1'b0, 0);
    end

    // ---- 4: restart after 6 bits, no stale bits ----
    do_reset("t4 reset");
    step(1'b1, 1'b0, 1'b0);
    send_bits("t4 partial", 10'h2CE, 6, 0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1);
    chk_dut("t4 restart", 0, '0, 1'b0, 1'b1, 1'b0, 0);
    v = 10'h3FF;
    send_bits("t4", v, KW, 0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    chk_dut("t4 commit", 0, v, 1'b1, 1'b0, 1'b0, 0);

    // ---- 5: reload behaviour in LOCKED ----
    do_reset("t5 reset");
    v = 10'h2CE;
    step(1'b1, 1'b0, 1'b0);
    send_bits("t5 lock", v, KW, 0, 1'b1, 1'b1);
    step(1'b0, 1'b1, ^v);
    rk = 10'h0F0;
    step(1'b1, 1'b1, 1'b1);
    chk_dut("t5 reload0", 0, v, 1'b1, 1'b0, 1'b0, 0);
    chk_dut("t5 reload1", 1, v, 1'b1, 1'b1, 1'b0, 0);
    send_bits("t5 new", rk, KW, 0, 1'b0, 1'b1);
    chk_dut("t5 held1", 1, v, 1'b1, 1'b1, 1'b0, KW);
    step(1'b0, 1'b1, ^rk);
    chk_dut("t5 new0", 0, v, 1'b1, 1'b0, 1'b0, 0);
    chk_dut("t5 new1", 1, rk, 1'b1, 1'b0, 1'b0, 0);
    step(1'b1, 1'b0, 1'b0);
    send_bits("t5 bad", 10'h155, KW, 0, 1'b0, 1'b1);
    step(1'b0, 1'b1, ~(^10'h155));
    chk_dut("t5 badreload0", 0, v, 1'b1, 1'b0, 1'b0, 0);
    chk_dut("t5 badreload1", 1, '0, 1'b0, 1'b0, 1'b1, 0);

    // ---- 6: async reset mid-load and after commit ----
    step(1'b1, 1'b0, 1'b0);
    send_bits("t6 mid", 10'h1A5, 7, 0, 1'b0, 1'b1);
    do_reset("t6 mid reset");
    step(1'b1, 1'b0, 1'b0);
    send_bits("t6", 10'h2CE, KW, 0, 1'b1, 1'b1);
    step(1'b0, 1'b1, ^10'h2CE);
    chk_dut("t6 commit", 0, 10'h2CE, 1'b1, 1'b0, 1'b0, 0);
    do_reset("t6 post reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
